time_keeper: RTL

- BCD time-of-day source: hours, minutes and seconds.
- Drives the curAlarmHour/curMin inputs of the alarm comparator and the display mux.
- Counts on a prescaled 1 Hz enable derived from CLK.
- Manual set mode: a two-bit button input steps the minute and hour fields, with the same bit mapping the alarm-set path uses.

---
 rtl/clock_pkg.sv | 8 +
 rtl/bcd_mod60.sv | 19 +
 rtl/time_keeper.sv | 64 ++++++
 3 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared BCD time types, limits and button bit indices
package clock_pkg;
    typedef logic [7:0] bcd2_t;
    localparam bcd2_t MIN_SEC_MAX = 8'h59;
    localparam bcd2_t HOUR_MAX = 8'h23;
    localparam int BTN_MIN = 0;
    localparam int BTN_HOUR = 1;
endpackage

// File: rtl/bcd_mod60.sv
// bcd_mod60: two-digit BCD 00..59 counter with enable, clear, wrap and carry-out
module bcd_mod60
    import clock_pkg::*;
(
    input  logic  CLK,
    input  logic  CR,
    input  logic  clr,
    input  logic  en,
    output bcd2_t value,
    output logic  carry
);
    assign carry = en && value == MIN_SEC_MAX;
    // Clear wins over counting; 59 wraps to 00 and raises carry for one enabled cycle
    always_ff @(posedge CLK or posedge CR) begin
        if (CR) value <= '0;
        else if (clr) value <= '0;
        else if (en) value <= carry ? '0 : value[3:0] == 4'h9 ? {value[7:4] + 4'h1, 4'h0} : value + 8'h01;
    end
endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss time-of-day counter with 1 Hz prescaler and button set mode
module time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int HOLD_SEC_IN_SET = 1
)(
    input  logic       CLK,
    input  logic       CR,
    input  logic       setMode,
    input  logic [1:0] settingButton,
    output bcd2_t      curHour,
    output bcd2_t      curMin,
    output bcd2_t      curSec,
    output logic       secTick,
    output logic       minTick,
    output logic       hourChime
);
    localparam int CW = $clog2(CLK_DIV);
    logic [CW-1:0] preCnt;
    logic [1:0] btnQ, btnRise;
    logic tick1, secClr, secEn, secCarry, minEn, minCarry, hourInc;
    bcd2_t nextHour;
    assign tick1 = preCnt == CW'(CLK_DIV - 1);
    assign secClr = setMode && HOLD_SEC_IN_SET != 0;
    assign secEn = tick1 && !setMode;
    assign minEn = setMode ? btnRise[BTN_MIN] : secCarry;
    assign hourInc = setMode ? btnRise[BTN_HOUR] : minCarry;
    assign nextHour = curHour == HOUR_MAX ? '0 : curHour[3:0] == 4'h9 ? {curHour[7:4] + 4'h1, 4'h0} : curHour + 8'h01;
    // Prescaler parks at 0 in set mode so leaving it gives a full second before the next tick
    always_ff @(posedge CLK or posedge CR) begin
        if (CR) preCnt <= '0;
        else preCnt <= (setMode || tick1) ? '0 : preCnt + 1'b1;
    end
    // Registered rise detect: one step per press however long the button is held
    always_ff @(posedge CLK or posedge CR) begin
        if (CR) begin
            btnQ <= '0;
            btnRise <= '0;
        end else begin
            btnQ <= settingButton;
            btnRise <= settingButton & ~btnQ;
        end
    end
    bcd_mod60 uSec (.CLK(CLK), .CR(CR), .clr(secClr), .en(secEn), .value(curSec), .carry(secCarry));
    bcd_mod60 uMin (.CLK(CLK), .CR(CR), .clr(1'b0), .en(minEn), .value(curMin), .carry(minCarry));
    // Hour wraps at 23; in set mode only the hour button moves it
    always_ff @(posedge CLK or posedge CR) begin
        if (CR) curHour <= '0;
        else if (hourInc) curHour <= nextHour;
    end
    // Event pulses registered alongside the fields they describe
    always_ff @(posedge CLK or posedge CR) begin
        if (CR) begin
            secTick <= 1'b0;
            minTick <= 1'b0;
            hourChime <= 1'b0;
        end else begin
            secTick <= secEn;
            minTick <= minEn;
            hourChime <= hourInc && !setMode;
        end
    end
endmodule
